// File: rtl/bsg_fsb_node_client_adapter.sv
// FSB ring <-> test node client adapter: destid filter, two small FIFOs,
// saturating debug counters.

// Circular FIFO with occupancy count; no enqueue->dequeue bypass.
module bsg_fsb_node_client_adapter_fifo #(
    parameter int unsigned width_p = 80,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enq,
    input  logic [width_p-1:0] wdata,
    input  logic               deq,
    output logic [width_p-1:0] rdata,
    output logic               full,
    output logic               empty
);
    localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count;

    assign full  = (count == cnt_w'(els_p));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping, pointers wrap modulo els_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= (wr_ptr == ptr_w'(els_p - 1)) ? '0 : wr_ptr + ptr_w'(1);
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == ptr_w'(els_p - 1)) ? '0 : rd_ptr + ptr_w'(1);
            end
            if (enq && !deq) begin
                count <= count + cnt_w'(1);
            end else if (!enq && deq) begin
                count <= count - cnt_w'(1);
            end
        end
    end
endmodule

module bsg_fsb_node_client_adapter #(
    parameter int unsigned ring_width_p  = 80,
    parameter int unsigned id_p          = 0,
    parameter int unsigned fifo_els_p    = 2,
    parameter int unsigned count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  logic                     fsb_v_i,
    input  logic [ring_width_p-1:0]  fsb_data_i,
    output logic                     fsb_ready_o,
    output logic                     node_v_o,
    output logic [ring_width_p-1:0]  node_data_o,
    input  logic                     node_ready_i,
    input  logic                     node_v_i,
    input  logic [ring_width_p-1:0]  node_data_i,
    output logic                     node_yumi_o,
    output logic                     fsb_v_o,
    output logic [ring_width_p-1:0]  fsb_data_o,
    input  logic                     fsb_ready_i,
    output logic [count_width_p-1:0] rx_count_o,
    output logic [count_width_p-1:0] tx_count_o,
    output logic [count_width_p-1:0] drop_count_o
);
    localparam int unsigned id_w = 4;
    localparam logic [count_width_p-1:0] count_max = {count_width_p{1'b1}};

    logic in_full, in_empty, out_full, out_empty;
    logic drop, in_enq, in_deq, drop_inc, out_deq;

    // A packet is dropped when the node is disabled or it is addressed elsewhere;
    // such packets are always acceptable regardless of FIFO occupancy.
    assign drop        = !en_i || (fsb_data_i[ring_width_p-1 -: id_w] != id_w'(id_p));
    assign fsb_ready_o = !in_full || drop;
    assign in_enq      = fsb_v_i && fsb_ready_o && !drop;
    assign drop_inc    = fsb_v_i && fsb_ready_o && drop;

    assign node_v_o    = !in_empty;
    assign in_deq      = node_v_o && node_ready_i;

    assign node_yumi_o = node_v_i && en_i && !out_full;
    assign fsb_v_o     = !out_empty;
    assign out_deq     = fsb_v_o && fsb_ready_i;

    bsg_fsb_node_client_adapter_fifo #(
        .width_p (ring_width_p),
        .els_p   (fifo_els_p)
    ) in_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .enq   (in_enq),
        .wdata (fsb_data_i),
        .deq   (in_deq),
        .rdata (node_data_o),
        .full  (in_full),
        .empty (in_empty)
    );

    bsg_fsb_node_client_adapter_fifo #(
        .width_p (ring_width_p),
        .els_p   (fifo_els_p)
    ) out_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .enq   (node_yumi_o),
        .wdata (node_data_i),
        .deq   (out_deq),
        .rdata (fsb_data_o),
        .full  (out_full),
        .empty (out_empty)
    );

    // Saturating debug counters for delivered, transmitted and dropped packets.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_count_o   <= '0;
            tx_count_o   <= '0;
            drop_count_o <= '0;
        end else begin
            if (in_deq && rx_count_o != count_max) begin
                rx_count_o <= rx_count_o + count_width_p'(1);
            end
            if (out_deq && tx_count_o != count_max) begin
                tx_count_o <= tx_count_o + count_width_p'(1);
            end
            if (drop_inc && drop_count_o != count_max) begin
                drop_count_o <= drop_count_o + count_width_p'(1);
            end
        end
    end
endmodule

// File: tb/tb_bsg_fsb_node_client_adapter.sv
// Directed bench for bsg_fsb_node_client_adapter with a queue-based reference model.
module tb_bsg_fsb_node_client_adapter;
    localparam int unsigned RW = 80;
    localparam int unsigned CW = 2;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          en_i;
    logic          fsb_v_i;
    logic [RW-1:0] fsb_data_i;
    logic          fsb_ready_o;
    logic          node_v_o;
    logic [RW-1:0] node_data_o;
    logic          node_ready_i;
    logic          node_v_i;
    logic [RW-1:0] node_data_i;
    logic          node_yumi_o;
    logic          fsb_v_o;
    logic [RW-1:0] fsb_data_o;
    logic          fsb_ready_i;
    logic [CW-1:0] rx_count_o;
    logic [CW-1:0] tx_count_o;
    logic [CW-1:0] drop_count_o;

    bsg_fsb_node_client_adapter #(
        .ring_width_p  (RW),
        .id_p          (3),
        .fifo_els_p    (2),
        .count_width_p (CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .en_i         (en_i),
        .fsb_v_i      (fsb_v_i),
        .fsb_data_i   (fsb_data_i),
        .fsb_ready_o  (fsb_ready_o),
        .node_v_o     (node_v_o),
        .node_data_o  (node_data_o),
        .node_ready_i (node_ready_i),
        .node_v_i     (node_v_i),
        .node_data_i  (node_data_i),
        .node_yumi_o  (node_yumi_o),
        .fsb_v_o      (fsb_v_o),
        .fsb_data_o   (fsb_data_o),
        .fsb_ready_i  (fsb_ready_i),
        .rx_count_o   (rx_count_o),
        .tx_count_o   (tx_count_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int            errors = 0;
    int            checks = 0;
    logic [RW-1:0] in_q [$];
    logic [RW-1:0] out_q [$];
    logic [CW-1:0] m_rx, m_tx, m_drop;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    function automatic logic [RW-1:0] pkt(input logic [3:0] d);
        logic [RW-1:0] p;
        p[31:0]  = $urandom;
        p[63:32] = $urandom;
        p[79:64] = 16'($urandom);
        p[RW-1 -: 4] = d;
        return p;
    endfunction

    // Check every output against the model for this cycle, then advance the model.
    task automatic step(input string tag);
        logic match, e_ready, e_nv, e_fv, e_yumi;
        #1;
        match   = en_i && (fsb_data_i[RW-1 -: 4] == 4'd3);
        e_ready = (in_q.size() < 2) || !match;
        e_nv    = (in_q.size() != 0);
        e_fv    = (out_q.size() != 0);
        e_yumi  = node_v_i && en_i && (out_q.size() < 2);
        chk({tag, ".fsb_ready"}, RW'(fsb_ready_o), RW'(e_ready));
        chk({tag, ".node_v"},    RW'(node_v_o),    RW'(e_nv));
        chk({tag, ".fsb_v"},     RW'(fsb_v_o),     RW'(e_fv));
        chk({tag, ".yumi"},      RW'(node_yumi_o), RW'(e_yumi));
        chk({tag, ".rx"},        RW'(rx_count_o),  RW'(m_rx));
        chk({tag, ".tx"},        RW'(tx_count_o),  RW'(m_tx));
        chk({tag, ".drop"},      RW'(drop_count_o), RW'(m_drop));
        if (e_nv) chk({tag, ".node_data"}, node_data_o, in_q[0]);
        if (e_fv) chk({tag, ".fsb_data"},  fsb_data_o,  out_q[0]);
        if (e_nv && node_ready_i) begin
            void'(in_q.pop_front());
            m_rx = sat(m_rx);
        end
        if (e_fv && fsb_ready_i) begin
            void'(out_q.pop_front());
            m_tx = sat(m_tx);
        end
        if (fsb_v_i && e_ready) begin
            if (match) in_q.push_back(fsb_data_i);
            else       m_drop = sat(m_drop);
        end
        if (e_yumi) out_q.push_back(node_data_i);
        @(negedge clk_i);
    endtask

    // Assert reset, check outputs with no clock edge, release on the next falling edge.
    task automatic do_reset(input string tag);
        reset_n_i = 1'b0;
        #1;
        chk({tag, ".fsb_ready"}, RW'(fsb_ready_o), RW'(1'b1));
        chk({tag, ".node_v"},    RW'(node_v_o),    RW'(1'b0));
        chk({tag, ".fsb_v"},     RW'(fsb_v_o),     RW'(1'b0));
        chk({tag, ".yumi"},      RW'(node_yumi_o), RW'(node_v_i && en_i));
        chk({tag, ".rx"},        RW'(rx_count_o),  RW'(0));
        chk({tag, ".tx"},        RW'(tx_count_o),  RW'(0));
        chk({tag, ".drop"},      RW'(drop_count_o), RW'(0));
        in_q.delete();
        out_q.delete();
        m_rx = '0; m_tx = '0; m_drop = '0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        reset_n_i = 1'b0; en_i = 1'b0; fsb_v_i = 1'b0; fsb_data_i = '0;
        node_ready_i = 1'b0; node_v_i = 1'b0; node_data_i = '0; fsb_ready_i = 1'b0;
        m_rx = '0; m_tx = '0; m_drop = '0;

        // Three matching packets streamed to a ready node.
        do_reset("rst0");
        en_i = 1'b1; node_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fsb_v_i = 1'b1; fsb_data_i = pkt(4'd3);
            step("stream");
        end
        fsb_v_i = 1'b0;
        repeat (3) step("stream_drain");
        chk("stream.rx_final", RW'(rx_count_o), RW'(3));
        chk("stream.drop_final", RW'(drop_count_o), RW'(0));

        // Backpressure: third packet waits until the first dequeue.
        do_reset("rst1");
        node_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fsb_v_i = 1'b1; fsb_data_i = pkt(4'd3);
            step("bp_fill");
        end
        node_ready_i = 1'b1;
        step("bp_release");
        step("bp_accept");

        // Mismatched destid accepted and dropped while the FIFO is full.
        node_ready_i = 1'b0;
        fsb_data_i = pkt(4'd3);
        step("refill");
        step("full_block");
        fsb_data_i = pkt(4'd5);
        step("drop_full");
        fsb_v_i = 1'b0; node_ready_i = 1'b1;
        repeat (3) step("drop_drain");
        chk("drop_full.count", RW'(drop_count_o), RW'(1));

        // Disable with a queued packet.
        do_reset("rst2");
        en_i = 1'b1; node_ready_i = 1'b0;
        fsb_v_i = 1'b1; fsb_data_i = pkt(4'd3);
        step("en_q");
        en_i = 1'b0; fsb_data_i = pkt(4'd3);
        node_v_i = 1'b1; node_data_i = pkt(4'd7);
        step("en_off");
        fsb_v_i = 1'b0; node_ready_i = 1'b1;
        repeat (2) step("en_drain");
        chk("en_off.rx", RW'(rx_count_o), RW'(1));
        chk("en_off.drop", RW'(drop_count_o), RW'(1));
        node_v_i = 1'b0;

        // Outbound with alternating ring readiness.
        do_reset("rst3");
        en_i = 1'b1; node_v_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            node_data_i = pkt(4'(i));
            fsb_ready_i = 1'(i % 2);
            step("out_alt");
        end
        node_v_i = 1'b0; fsb_ready_i = 1'b1;
        repeat (3) step("out_drain");
        chk("out.tx_sat", RW'(tx_count_o), RW'(3));

        // Drop counter saturation, then mid-stream asynchronous reset.
        do_reset("rst4");
        for (int i = 0; i < 5; i++) begin
            fsb_v_i = 1'b1; fsb_data_i = pkt(4'd5);
            step("sat");
        end
        chk("sat.drop", RW'(drop_count_o), RW'(3));
        fsb_data_i = pkt(4'd3); node_ready_i = 1'b0; fsb_ready_i = 1'b0;
        node_v_i = 1'b1; node_data_i = pkt(4'd9);
        step("busy");
        step("busy2");
        do_reset("rst_mid");
        fsb_v_i = 1'b0; node_v_i = 1'b0;
        repeat (2) step("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
